// File: rtl/ahb_slave_pkg.sv
// Shared encodings for the AHB-Lite register-file responder: bus field
// encodings, data width and the data-phase FSM state codes.
package ahb_slave_pkg;

  localparam int DATA_W = 32;

  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Data-phase FSM: IDLE means no data phase of ours is pending.
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_ACCESS = 3'd1;
  localparam state_t ST_WAIT   = 3'd2;
  localparam state_t ST_ERR1   = 3'd3;
  localparam state_t ST_ERR2   = 3'd4;

endpackage

// File: rtl/ahb_slave_regfile_if.sv
// AHB-Lite signal bundle between the bus master side and the register-file
// responder. HREADY is the bus-level ready seen by every slave.
interface ahb_slave_regfile_if import ahb_slave_pkg::*; #(
  parameter int ADDR_W = 16
);
  logic              HSEL;
  logic [ADDR_W-1:0] HADDR;
  logic [1:0]        HTRANS;
  logic              HWRITE;
  logic [2:0]        HSIZE;
  logic [2:0]        HBURST;
  logic [DATA_W-1:0] HWDATA;
  logic              HREADY;
  logic              HREADYOUT;
  logic              HRESP;
  logic [DATA_W-1:0] HRDATA;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADY,
    input  HREADYOUT, HRESP, HRDATA
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADY,
    output HREADYOUT, HRESP, HRDATA
  );
endinterface

// File: rtl/ahb_byte_lane_dec.sv
// Little-endian byte-lane decoder: turns HSIZE and the low address bits into
// a 4-bit write strobe. The misaligned flag also covers unsupported sizes so
// the top only has one "bad access shape" signal to look at.
module ahb_byte_lane_dec import ahb_slave_pkg::*; (
  input  logic [2:0] size,
  input  logic [1:0] addr_lo,
  output logic [3:0] strobe,
  output logic       misaligned
);

  // Lane selection and alignment check for the three legal sizes.
  always_comb begin
    strobe     = 4'b0000;
    misaligned = 1'b0;
    case (size)
      HSIZE_BYTE: strobe = 4'b0001 << addr_lo;
      HSIZE_HALF: begin
        strobe     = addr_lo[1] ? 4'b1100 : 4'b0011;
        misaligned = addr_lo[0];
      end
      HSIZE_WORD: begin
        strobe     = 4'b1111;
        misaligned = |addr_lo;
      end
      default: misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/ahb_slave_regfile.sv
// AHB-Lite responder in front of a DEPTH x 32-bit register file, with an
// independent registered debug read port. Optional data-phase wait states are
// built only when AHB_SLAVE_WAIT_EN is defined; otherwise every OKAY transfer
// is zero-wait and WAIT_STATES has no effect. The interface instance must use
// the same ADDR_W as this module.
module ahb_slave_regfile import ahb_slave_pkg::*; #(
  parameter int DEPTH       = 16,
  parameter int ADDR_W      = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic               HCLK,
  input  logic               HRESETn,
  ahb_slave_regfile_if.slave bus,
  input  logic [15:0]        dbg_addr,
  output logic [DATA_W-1:0]  dbg_data
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  state_t            state;
  logic [IDX_W-1:0]  addr_q;
  logic              write_q;
  logic [3:0]        strobe_q;
  logic [3:0]        strobe;
  logic              misaligned;
  logic              sel_xfer;
  logic              out_of_range;
  logic              hready_out;
  logic              hresp;
  logic              read_active;
  logic [IDX_W-1:0]  haddr_idx;
  logic [2:0]        unused_burst_cfg;

`ifdef AHB_SLAVE_WAIT_EN
  logic [2:0]        wait_cnt;
`endif

  ahb_byte_lane_dec u_lane_dec (
    .size       (bus.HSIZE),
    .addr_lo    (bus.HADDR[1:0]),
    .strobe     (strobe),
    .misaligned (misaligned)
  );

  // HBURST is ignored (every beat stands alone); WAIT_STATES only matters
  // when wait support is built in.
  assign unused_burst_cfg = bus.HBURST ^ 3'(WAIT_STATES);

  assign haddr_idx    = bus.HADDR[IDX_W+1:2];
  assign out_of_range = |bus.HADDR[ADDR_W-1:IDX_W+2];
  assign sel_xfer     = bus.HSEL & bus.HREADY &
                        ((bus.HTRANS == HTRANS_NONSEQ) | (bus.HTRANS == HTRANS_SEQ));

  // Ready/response are pure functions of the data-phase state.
  always_comb begin
    hready_out = 1'b1;
    hresp      = HRESP_OKAY;
    case (state)
      ST_ERR1: begin
        hready_out = 1'b0;
        hresp      = HRESP_ERROR;
      end
      ST_ERR2: hresp = HRESP_ERROR;
`ifdef AHB_SLAVE_WAIT_EN
      ST_WAIT: hready_out = 1'b0;
`endif
      default: ;
    endcase
  end

  assign read_active   = !write_q && ((state == ST_ACCESS) || (state == ST_WAIT));
  assign bus.HREADYOUT = hready_out;
  assign bus.HRESP     = hresp;
  assign bus.HRDATA    = read_active ? mem[addr_q] : '0;

  // Address-phase capture and data-phase sequencing; a new transfer is taken
  // on the same edge the current data phase completes.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state    <= ST_IDLE;
      addr_q   <= '0;
      write_q  <= 1'b0;
      strobe_q <= 4'b0000;
`ifdef AHB_SLAVE_WAIT_EN
      wait_cnt <= 3'd0;
`endif
    end else if (hready_out) begin
      if (sel_xfer) begin
        addr_q   <= haddr_idx;
        write_q  <= bus.HWRITE;
        strobe_q <= strobe;
        if (out_of_range || misaligned) begin
          state <= ST_ERR1;
`ifdef AHB_SLAVE_WAIT_EN
        end else if (WAIT_STATES != 0) begin
          state    <= ST_WAIT;
          wait_cnt <= 3'(WAIT_STATES);
`endif
        end else begin
          state <= ST_ACCESS;
        end
      end else begin
        state <= ST_IDLE;
      end
    end else begin
      case (state)
        ST_ERR1: state <= ST_ERR2;
`ifdef AHB_SLAVE_WAIT_EN
        ST_WAIT: begin
          wait_cnt <= wait_cnt - 3'd1;
          if (wait_cnt == 3'd1) state <= ST_ACCESS;
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Byte-lane write commit on the completing edge of a legal write.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (state == ST_ACCESS && write_q) begin
      for (int b = 0; b < 4; b++) begin
        if (strobe_q[b]) mem[addr_q][8*b +: 8] <= bus.HWDATA[8*b +: 8];
      end
    end
  end

  // Debug read port, one cycle latency, zero outside the register file.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dbg_data <= '0;
    end else if (|dbg_addr[15:IDX_W]) begin
      dbg_data <= '0;
    end else begin
      dbg_data <= mem[dbg_addr[IDX_W-1:0]];
    end
  end

endmodule

// File: tb/tb_ahb_slave_regfile.sv
// Self-checking bench for ahb_slave_regfile. A pipelined bus driver plays a
// list of transfers (with HREADY fed back from HREADYOUT, as in a single-slave
// system) and records what each data phase looked like; a word/byte-level
// memory model decides what every data phase should have looked like.
module tb_ahb_slave_regfile;

  localparam int DEPTH = 16;
  localparam int WAITS_PARAM = 3;
`ifdef AHB_SLAVE_WAIT_EN
  localparam int EXP_WAITS = WAITS_PARAM;
`else
  localparam int EXP_WAITS = 0;
`endif

  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic        write;
    logic [15:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
  } xfer_t;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic [15:0] dbg_addr;
  logic [31:0] dbg_data;

  xfer_t       xf [64];
  int          xf_n;
  int          obs_low [64];
  int          obs_resp [64];
  logic [31:0] obs_rdata [64];
  logic [31:0] model_mem [DEPTH];
  int          total = 0;
  int          bad = 0;

  ahb_slave_regfile_if #(.ADDR_W(16)) bus ();

  assign bus.HREADY = bus.HREADYOUT;

  ahb_slave_regfile #(.DEPTH(DEPTH), .ADDR_W(16), .WAIT_STATES(WAITS_PARAM)) dut (
    .HCLK     (HCLK),
    .HRESETn  (HRESETn),
    .bus      (bus),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  always #5 HCLK = ~HCLK;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic drive_idle();
    bus.HSEL   = 1'b0;
    bus.HTRANS = 2'd0;
    bus.HWRITE = 1'b0;
    bus.HADDR  = 16'h0;
    bus.HSIZE  = 3'd0;
    bus.HBURST = 3'd0;
    bus.HWDATA = 32'h0;
  endtask

  task automatic add_xfer(input logic sel, input logic [1:0] trans, input logic write,
                          input logic [15:0] addr, input logic [2:0] size, input logic [31:0] wdata);
    if (xf_n < 64) begin
      xf[xf_n] = '{sel, trans, write, addr, size, wdata};
      xf_n++;
    end
  endtask

  // Expected data phase of transfer i under the bus rules; updates the model.
  task automatic model_expect(input int i, output int e_low, output int e_resp, output logic [31:0] e_rdata);
    int widx, lane;
    bit ill, hit;
    e_low = 0; e_resp = 0; e_rdata = 32'h0;
    if (!(xf[i].sel && xf[i].trans >= 2'd2)) return;
    widx = int'(xf[i].addr) / 4;
    lane = int'(xf[i].addr) % 4;
    ill = (widx >= DEPTH) || (xf[i].size > 3'd2) ||
          (xf[i].size == 3'd1 && (lane % 2) != 0) || (xf[i].size == 3'd2 && lane != 0);
    if (ill) begin
      e_low = 1; e_resp = 2;
      return;
    end
    e_low = EXP_WAITS;
    if (!xf[i].write) begin
      e_rdata = model_mem[widx];
    end else begin
      for (int b = 0; b < 4; b++) begin
        hit = (xf[i].size == 3'd2) || (xf[i].size == 3'd1 && b / 2 == lane / 2) ||
              (xf[i].size == 3'd0 && b == lane);
        if (hit) model_mem[widx][8*b +: 8] = xf[i].wdata[8*b +: 8];
      end
    end
  endtask

  // Pipelined driver: address phase of the next transfer overlaps the data
  // phase of the current one; records each data phase's shape.
  task automatic run_xfers();
    int idx, dp, cycles;
    logic ready;
    idx = 0; dp = -1; cycles = 0;
    for (int i = 0; i < xf_n; i++) begin
      obs_low[i] = 0; obs_resp[i] = 0; obs_rdata[i] = 32'h0;
    end
    @(posedge HCLK); #1;
    while ((idx < xf_n || dp >= 0) && cycles < 20 * xf_n + 20) begin
      if (idx < xf_n) begin
        bus.HSEL   = xf[idx].sel;
        bus.HTRANS = xf[idx].trans;
        bus.HWRITE = xf[idx].write;
        bus.HADDR  = xf[idx].addr;
        bus.HSIZE  = xf[idx].size;
        bus.HBURST = 3'($urandom_range(0, 7));
      end else begin
        bus.HSEL = 1'b0; bus.HTRANS = 2'd0;
      end
      bus.HWDATA = (dp >= 0) ? xf[dp].wdata : $urandom;
      @(negedge HCLK);
      ready = bus.HREADYOUT;
      if (dp >= 0) begin
        if (bus.HRESP) obs_resp[dp]++;
        if (!bus.HREADYOUT) obs_low[dp]++;
        else obs_rdata[dp] = bus.HRDATA;
      end
      @(posedge HCLK); #1;
      cycles++;
      if (ready) begin
        dp = (idx < xf_n) ? idx : -1;
        if (idx < xf_n) idx++;
      end
    end
    total++;
    if (idx < xf_n || dp >= 0) begin
      bad++;
      $display("[TB] FAIL bus_timeout: got %0d of %0d transfers done, want all", idx, xf_n);
    end
    drive_idle();
  endtask

  task automatic test_reset();
    HRESETn = 1'b0;
    dbg_addr = 16'h0;
    drive_idle();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
    #2;
    total++;
    if (bus.HREADYOUT !== 1'b1) begin bad++; $display("[TB] FAIL reset_hreadyout: got %b want 1", bus.HREADYOUT); end
    total++;
    if (bus.HRESP !== 1'b0) begin bad++; $display("[TB] FAIL reset_hresp: got %b want 0", bus.HRESP); end
    total++;
    if (bus.HRDATA !== 32'h0) begin bad++; $display("[TB] FAIL reset_hrdata: got %h want 0", bus.HRDATA); end
    total++;
    if (dbg_data !== 32'h0) begin bad++; $display("[TB] FAIL reset_dbg: got %h want 0", dbg_data); end
    #20 HRESETn = 1'b1;
  endtask

  task automatic test_word_rw();
    int e_low, e_resp;
    logic [31:0] e_rd;
    xf_n = 0;
    add_xfer(1, 2, 1, 16'h0008, 2, 32'hDEADBEEF);
    add_xfer(1, 0, 0, 16'h0008, 2, 32'h0);
    add_xfer(1, 2, 0, 16'h0008, 2, 32'h0);
    add_xfer(1, 2, 1, 16'h0008, 2, 32'h11223344);
    add_xfer(1, 2, 1, 16'h000B, 0, 32'hAA000000);
    add_xfer(1, 2, 0, 16'h0008, 2, 32'h0);
    add_xfer(1, 3, 1, 16'h0008, 1, 32'h00005566);
    add_xfer(1, 3, 0, 16'h0008, 2, 32'h0);
    add_xfer(0, 2, 1, 16'h0008, 2, 32'hFFFFFFFF);
    add_xfer(1, 1, 1, 16'h0008, 2, 32'hFFFFFFFF);
    add_xfer(1, 2, 0, 16'h0008, 2, 32'h0);
    run_xfers();
    for (int i = 0; i < xf_n; i++) begin
      model_expect(i, e_low, e_resp, e_rd);
      total++;
      if (obs_low[i] !== e_low || obs_resp[i] !== e_resp || obs_rdata[i] !== e_rd) begin
        bad++;
        $display("[TB] FAIL word_rw xfer%0d: got low=%0d resp=%0d rdata=%h, want low=%0d resp=%0d rdata=%h",
                 i, obs_low[i], obs_resp[i], obs_rdata[i], e_low, e_resp, e_rd);
      end
    end
    total++;
    if (obs_rdata[2] !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL word_read: got %h want deadbeef", obs_rdata[2]); end
    total++;
    if (obs_rdata[5] !== 32'hAA223344) begin bad++; $display("[TB] FAIL byte_merge: got %h want aa223344", obs_rdata[5]); end
    total++;
    if (obs_rdata[7] !== 32'hAA225566) begin bad++; $display("[TB] FAIL half_merge: got %h want aa225566", obs_rdata[7]); end
    total++;
    if (obs_rdata[10] !== 32'hAA225566) begin bad++; $display("[TB] FAIL no_sel_no_write: got %h want aa225566", obs_rdata[10]); end
    total++;
    if (obs_low[2] !== EXP_WAITS) begin bad++; $display("[TB] FAIL read_waits: got %0d want %0d", obs_low[2], EXP_WAITS); end
  endtask

  task automatic test_back_to_back();
    int e_low, e_resp;
    logic [31:0] e_rd;
    xf_n = 0;
    add_xfer(1, 2, 1, 16'h000C, 2, 32'h00000001);
    add_xfer(1, 2, 0, 16'h000C, 2, 32'h0);
    add_xfer(1, 3, 1, 16'h000E, 1, 32'hBEEF0000);
    add_xfer(1, 3, 0, 16'h000C, 2, 32'h0);
    add_xfer(1, 3, 1, 16'h000D, 0, 32'h00007700);
    add_xfer(1, 3, 0, 16'h000C, 2, 32'h0);
    run_xfers();
    for (int i = 0; i < xf_n; i++) begin
      model_expect(i, e_low, e_resp, e_rd);
      total++;
      if (obs_low[i] !== e_low || obs_resp[i] !== e_resp || obs_rdata[i] !== e_rd) begin
        bad++;
        $display("[TB] FAIL back_to_back xfer%0d: got low=%0d resp=%0d rdata=%h, want low=%0d resp=%0d rdata=%h",
                 i, obs_low[i], obs_resp[i], obs_rdata[i], e_low, e_resp, e_rd);
      end
    end
    total++;
    if (obs_rdata[1] !== 32'h00000001) begin bad++; $display("[TB] FAIL raw_same_word: got %h want 00000001", obs_rdata[1]); end
    total++;
    if (obs_rdata[5] !== 32'hBEEF7701) begin bad++; $display("[TB] FAIL raw_lanes: got %h want beef7701", obs_rdata[5]); end
  endtask

  task automatic test_errors();
    int e_low, e_resp;
    logic [31:0] e_rd;
    xf_n = 0;
    add_xfer(1, 2, 1, 16'h0000, 2, 32'h12345678);
    add_xfer(1, 2, 0, 16'h0040, 2, 32'h0);
    add_xfer(1, 2, 0, 16'h0001, 1, 32'h0);
    add_xfer(1, 2, 1, 16'h0001, 1, 32'hFFFFFFFF);
    add_xfer(1, 2, 1, 16'h0002, 2, 32'hFFFFFFFF);
    add_xfer(1, 2, 1, 16'h0000, 3, 32'hFFFFFFFF);
    add_xfer(1, 2, 1, 16'h0040, 2, 32'hFFFFFFFF);
    add_xfer(1, 2, 0, 16'h0000, 2, 32'h0);
    add_xfer(1, 2, 1, 16'h003C, 2, 32'h0F0F0F0F);
    add_xfer(1, 2, 0, 16'h003C, 2, 32'h0);
    run_xfers();
    for (int i = 0; i < xf_n; i++) begin
      model_expect(i, e_low, e_resp, e_rd);
      total++;
      if (obs_low[i] !== e_low || obs_resp[i] !== e_resp || obs_rdata[i] !== e_rd) begin
        bad++;
        $display("[TB] FAIL errors xfer%0d: got low=%0d resp=%0d rdata=%h, want low=%0d resp=%0d rdata=%h",
                 i, obs_low[i], obs_resp[i], obs_rdata[i], e_low, e_resp, e_rd);
      end
    end
    total++;
    if (obs_low[1] !== 1 || obs_resp[1] !== 2) begin
      bad++; $display("[TB] FAIL oob_error: got low=%0d resp=%0d want low=1 resp=2", obs_low[1], obs_resp[1]);
    end
    total++;
    if (obs_rdata[7] !== 32'h12345678) begin bad++; $display("[TB] FAIL error_no_write: got %h want 12345678", obs_rdata[7]); end
  endtask

  task automatic test_random();
    int e_low, e_resp;
    logic [31:0] e_rd;
    xf_n = 0;
    for (int k = 0; k < 48; k++) begin
      add_xfer(($urandom % 8) != 0, 2'($urandom_range(0, 3)), 1'($urandom % 2),
               16'($urandom_range(0, 71)),
               (($urandom % 8) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2)),
               $urandom);
    end
    run_xfers();
    for (int i = 0; i < xf_n; i++) begin
      model_expect(i, e_low, e_resp, e_rd);
      total++;
      if (obs_low[i] !== e_low || obs_resp[i] !== e_resp || obs_rdata[i] !== e_rd) begin
        bad++;
        $display("[TB] FAIL random xfer%0d: got low=%0d resp=%0d rdata=%h, want low=%0d resp=%0d rdata=%h",
                 i, obs_low[i], obs_resp[i], obs_rdata[i], e_low, e_resp, e_rd);
      end
    end
  endtask

  task automatic test_debug();
    int e_low, e_resp;
    logic [31:0] e_rd, e_dbg;
    logic [15:0] probe [DEPTH + 3];
    xf_n = 0;
    add_xfer(1, 2, 1, 16'h0000, 2, 32'h11111111);
    add_xfer(1, 2, 1, 16'h0008, 2, 32'hCAFEF00D);
    run_xfers();
    for (int i = 0; i < xf_n; i++) begin
      model_expect(i, e_low, e_resp, e_rd);
      total++;
      if (obs_low[i] !== e_low || obs_resp[i] !== e_resp || obs_rdata[i] !== e_rd) begin
        bad++;
        $display("[TB] FAIL debug_setup xfer%0d: got low=%0d resp=%0d rdata=%h, want low=%0d resp=%0d rdata=%h",
                 i, obs_low[i], obs_resp[i], obs_rdata[i], e_low, e_resp, e_rd);
      end
    end
    dbg_addr = 16'd0;
    @(posedge HCLK); #1;
    dbg_addr = 16'd2;
    @(negedge HCLK);
    total++;
    if (dbg_data !== 32'h11111111) begin bad++; $display("[TB] FAIL dbg_latency: got %h want 11111111", dbg_data); end
    @(negedge HCLK);
    total++;
    if (dbg_data !== 32'hCAFEF00D) begin bad++; $display("[TB] FAIL dbg_word2: got %h want cafef00d", dbg_data); end
    for (int k = 0; k < DEPTH; k++) probe[k] = 16'(k);
    probe[DEPTH] = 16'(DEPTH);
    probe[DEPTH + 1] = 16'h0100;
    probe[DEPTH + 2] = 16'hFFFF;
    for (int k = 0; k < DEPTH + 3; k++) begin
      dbg_addr = probe[k];
      @(posedge HCLK);
      @(negedge HCLK);
      e_dbg = (int'(probe[k]) < DEPTH) ? model_mem[int'(probe[k])] : 32'h0;
      total++;
      if (dbg_data !== e_dbg) begin
        bad++; $display("[TB] FAIL dbg_sweep addr=%0d: got %h want %h", probe[k], dbg_data, e_dbg);
      end
    end
  endtask

  task automatic test_reset_mid();
    @(posedge HCLK); #1;
    bus.HSEL = 1'b1; bus.HTRANS = 2'd2; bus.HWRITE = 1'b1;
    bus.HADDR = 16'h0014; bus.HSIZE = 3'd2;
    @(posedge HCLK); #1;
    drive_idle();
    bus.HWDATA = 32'h5A5A5A5A;
    #2 HRESETn = 1'b0;
    #1;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
    total++;
    if (bus.HREADYOUT !== 1'b1 || bus.HRESP !== 1'b0 || bus.HRDATA !== 32'h0 || dbg_data !== 32'h0) begin
      bad++;
      $display("[TB] FAIL mid_reset_outputs: got rdy=%b resp=%b rdata=%h dbg=%h want 1 0 0 0",
               bus.HREADYOUT, bus.HRESP, bus.HRDATA, dbg_data);
    end
    @(posedge HCLK); #2;
    HRESETn = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      dbg_addr = 16'(k);
      @(posedge HCLK);
      @(negedge HCLK);
      total++;
      if (dbg_data !== model_mem[k]) begin
        bad++; $display("[TB] FAIL mid_reset_mem word=%0d: got %h want %h", k, dbg_data, model_mem[k]);
      end
    end
  endtask

  initial begin
    $display("[TB] start, expected wait states per OKAY transfer: %0d", EXP_WAITS);
    test_reset();
    test_word_rw();
    test_back_to_back();
    test_errors();
    test_random();
    test_debug();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
